// File: rtl/addsub_pkg.sv
// Shared types and defaults for the pipelined adder/subtractor.
package addsub_pkg;

  localparam int unsigned AddsubWidth  = 32;
  localparam int unsigned AddsubStages = 4;
  localparam int unsigned AddsubTagW   = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ADC = 2'd2,
    OP_SBC = 2'd3
  } addsub_op_t;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } addsub_flags_t;

  // Subtracting ops add the one's complement of B.
  function automatic logic op_invert_b(addsub_op_t op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

  // Carry into bit 0: SUB supplies the +1 of two's complement, ADC/SBC take the caller's carry.
  function automatic logic op_carry_in(addsub_op_t op, logic cin);
    logic c0;
    unique case (op)
      OP_ADD:  c0 = 1'b0;
      OP_SUB:  c0 = 1'b1;
      default: c0 = cin;
    endcase
    return c0;
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// One SEG-bit ripple segment of the pipelined carry chain.
module addsub_seg #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] s_o,
  output logic           cout_o,
  output logic           a_msb_o,
  output logic           b_msb_o
);

  logic [SEG:0] sum;

  // Segment sum with carry out in the extra top bit
  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, cin_i};
  end

  assign s_o     = sum[SEG-1:0];
  assign cout_o  = sum[SEG];
  assign a_msb_o = a_i[SEG-1];
  assign b_msb_o = b_i[SEG-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/sub: the carry chain is cut into STAGES registered segments with an
// elastic valid/ready pipeline that collapses bubbles under output backpressure.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = AddsubWidth,
  parameter int unsigned STAGES = AddsubStages,
  parameter int unsigned TAG_W  = AddsubTagW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  addsub_op_t       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic [TAG_W-1:0] out_tag
);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("addsub_pipe: WIDTH must be a non-zero multiple of STAGES");
  end

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned Last = STAGES - 1;

  // Stage state. s_q holds summed low bits below the stage boundary and raw A above it;
  // b_q carries the not-yet-consumed effective B bits.
  logic [STAGES-1:0] v_q, v_d, adv;
  logic [STAGES-1:0] c_q, z_q;
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic              ovf_q;

  // Per-stage source selection and segment results
  logic [STAGES-1:0] src_v, c_src, z_src, z_d;
  logic [STAGES-1:0] seg_c, seg_am, seg_bm;
  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [TAG_W-1:0]  tag_src [STAGES];
  logic [SEG-1:0]    seg_s [STAGES];

  logic [WIDTH-1:0]  in_b_eff;
  logic              in_c0;
  logic              ovf_d;
  addsub_flags_t     flags;

  // Condition the incoming request into a plain A + B_eff + c0 addition
  always_comb begin
    in_b_eff = op_invert_b(in_op) ? ~in_b : in_b;
    in_c0    = op_carry_in(in_op, in_cin);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] SegMask = WIDTH'({SEG{1'b1}}) << (k * SEG);

    if (k == 0) begin : g_head
      assign src_v[k]   = in_valid;
      assign a_src[k]   = in_a;
      assign b_src[k]   = in_b_eff;
      assign c_src[k]   = in_c0;
      assign z_src[k]   = 1'b1;
      assign tag_src[k] = in_tag;
    end else begin : g_body
      assign src_v[k]   = v_q[k-1];
      assign a_src[k]   = s_q[k-1];
      assign b_src[k]   = b_q[k-1];
      assign c_src[k]   = c_q[k-1];
      assign z_src[k]   = z_q[k-1];
      assign tag_src[k] = tag_q[k-1];
    end

    addsub_seg #(
      .SEG(SEG)
    ) u_seg (
      .a_i    (a_src[k][k*SEG +: SEG]),
      .b_i    (b_src[k][k*SEG +: SEG]),
      .cin_i  (c_src[k]),
      .s_o    (seg_s[k]),
      .cout_o (seg_c[k]),
      .a_msb_o(seg_am[k]),
      .b_msb_o(seg_bm[k])
    );

    // Splice this segment's sum into the travelling word
    assign s_d[k] = (a_src[k] & ~SegMask) | (WIDTH'(seg_s[k]) << (k * SEG));
    // Zero flag accumulates one segment at a time so no stage needs a full-width reduction
    assign z_d[k] = z_src[k] & ~(|seg_s[k]);
  end

  assign ovf_d = (seg_am[Last] == seg_bm[Last]) && (seg_s[Last][SEG-1] != seg_am[Last]);

  // A stage advances if it or any later stage has a hole, or the consumer takes the result
  always_comb begin
    logic hole;
    hole = 1'b0;
    adv  = '0;
    v_d  = v_q;
    for (int k = int'(Last); k >= 0; k--) begin
      hole   = hole | ~v_q[k];
      adv[k] = hole | out_ready;
      if (adv[k]) begin
        v_d[k] = src_v[k];
      end
    end
  end

  assign in_ready = adv[0];

  // Stage registers: valid follows the advance; data is captured only from a valid source
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      z_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < int'(STAGES); k++) begin
        s_q[k]   <= '0;
        b_q[k]   <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < int'(STAGES); k++) begin
        if (adv[k] && src_v[k]) begin
          s_q[k]   <= s_d[k];
          b_q[k]   <= b_src[k];
          c_q[k]   <= seg_c[k];
          z_q[k]   <= z_d[k];
          tag_q[k] <= tag_src[k];
        end
      end
      if (adv[Last] && src_v[Last]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign flags = '{cout: c_q[Last], ovf: ovf_q, zero: z_q[Last], neg: s_q[Last][WIDTH-1]};

  assign out_valid  = v_q[Last];
  assign out_result = s_q[Last];
  assign out_cout   = flags.cout;
  assign out_ovf    = flags.ovf;
  assign out_zero   = flags.zero;
  assign out_neg    = flags.neg;
  assign out_tag    = tag_q[Last];

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: a 32/4 instance with directed, stall and reset
// scenarios plus random traffic, and 64/8 and 8/1 instances under random traffic.
module tb_addsub_pipe;
  import addsub_pkg::*;

  localparam int Stages = 4;
  localparam int NRand  = 1000;

  typedef struct packed {
    logic [63:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
    logic [3:0]  tag;
  } resp_t;

  typedef struct packed {
    resp_t r;
    int    exp_cyc;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Main 32/4 instance
  logic rst_n_m, iv_m, ir_m, ov_m, or_m, cin_m, co_m, ovf_m, z_m, ng_m;
  addsub_op_t op_m;
  logic [31:0] a_m, b_m, res_m;
  logic [3:0] tag_m, otag_m;

  // 64/8 and 8/1 instances
  logic rst_n_v;
  logic iv_w, ir_w, ov_w, or_w, cin_w, co_w, ovf_w, z_w, ng_w;
  addsub_op_t op_w;
  logic [63:0] a_w, b_w, res_w;
  logic [3:0] tag_w, otag_w;
  logic iv_n, ir_n, ov_n, or_n, cin_n, co_n, ovf_n, z_n, ng_n;
  addsub_op_t op_n;
  logic [7:0] a_n, b_n, res_n;
  logic [3:0] tag_n, otag_n;

  addsub_pipe #(.WIDTH(32), .STAGES(4), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n_m), .in_valid(iv_m), .in_ready(ir_m), .in_op(op_m),
    .in_a(a_m), .in_b(b_m), .in_cin(cin_m), .in_tag(tag_m), .out_valid(ov_m),
    .out_ready(or_m), .out_result(res_m), .out_cout(co_m), .out_ovf(ovf_m),
    .out_zero(z_m), .out_neg(ng_m), .out_tag(otag_m)
  );

  addsub_pipe #(.WIDTH(64), .STAGES(8), .TAG_W(4)) u_dut_w (
    .clk(clk), .rst_n(rst_n_v), .in_valid(iv_w), .in_ready(ir_w), .in_op(op_w),
    .in_a(a_w), .in_b(b_w), .in_cin(cin_w), .in_tag(tag_w), .out_valid(ov_w),
    .out_ready(or_w), .out_result(res_w), .out_cout(co_w), .out_ovf(ovf_w),
    .out_zero(z_w), .out_neg(ng_w), .out_tag(otag_w)
  );

  addsub_pipe #(.WIDTH(8), .STAGES(1), .TAG_W(4)) u_dut_n (
    .clk(clk), .rst_n(rst_n_v), .in_valid(iv_n), .in_ready(ir_n), .in_op(op_n),
    .in_a(a_n), .in_b(b_n), .in_cin(cin_n), .in_tag(tag_n), .out_valid(ov_n),
    .out_ready(or_n), .out_result(res_n), .out_cout(co_n), .out_ovf(ovf_n),
    .out_zero(z_n), .out_neg(ng_n), .out_tag(otag_n)
  );

  // Reference: unsigned sum for result/carry, true signed sum range test for overflow.
  function automatic resp_t model(input addsub_op_t op, input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, input int w, input logic [3:0] tag);
    logic [63:0] mask, am, bm, r;
    logic [64:0] usum;
    logic signed [66:0] sa, sb, ssum, lim;
    logic c0;
    resp_t o;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bm   = ((op == OP_SUB || op == OP_SBC) ? ~b : b) & mask;
    c0   = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : cin;
    usum = {1'b0, am} + {1'b0, bm} + {64'd0, c0};
    r    = usum[63:0] & mask;
    sa   = $signed({3'b000, am});
    if (am[w-1]) sa = sa - (67'sd1 <<< w);
    sb   = $signed({3'b000, bm});
    if (bm[w-1]) sb = sb - (67'sd1 <<< w);
    ssum = sa + sb + $signed({66'd0, c0});
    lim  = 67'sd1 <<< (w - 1);
    o.res  = r;
    o.cout = usum[w];
    o.ovf  = (ssum >= lim) || (ssum < -lim);
    o.zero = (r == 64'd0);
    o.neg  = r[w-1];
    o.tag  = tag;
    return o;
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] mask, msb;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    msb  = 64'd1 << (w - 1);
    case ($urandom_range(7))
      0:       return mask;
      1:       return 64'd0;
      2:       return msb;
      3:       return msb - 64'd1;
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  function automatic resp_t cur_m();
    return '{res: 64'(res_m), cout: co_m, ovf: ovf_m, zero: z_m, neg: ng_m, tag: otag_m};
  endfunction

  task automatic check_resp(input string name, input resp_t got, input resp_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got res=%h c=%b v=%b z=%b n=%b tag=%h, want res=%h c=%b v=%b z=%b n=%b tag=%h",
               name, got.res, got.cout, got.ovf, got.zero, got.neg, got.tag,
               exp.res, exp.cout, exp.ovf, exp.zero, exp.neg, exp.tag);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic bad(input string name, input string msg);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s", name, msg);
  endtask

  sb_t q_m[$];
  sb_t q_w[$];
  sb_t q_n[$];

  bit saw_block = 0;
  bit rnd_mode  = 0;
  bit done_w    = 0;
  bit done_n    = 0;
  int stall_lo  = -10;
  int stall_hi  = -10;

  // Consumer readiness for the main instance: a fixed stall window or random
  initial begin : rdy_m
    or_m = 1'b1;
    forever begin
      @(negedge clk);
      or_m = rnd_mode ? ($urandom_range(3) != 0) : !(cyc >= stall_lo && cyc <= stall_hi);
    end
  end

  // Main monitor: pops on each output handshake, checks hold while stalled
  initial begin : mon_m
    resp_t cur, held;
    sb_t   e;
    bit    hold;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      cur = cur_m();
      if (!rst_n_m) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check_int("m_stall_valid", int'(ov_m), 1);
          check_resp("m_stall_hold", cur, held);
        end
        hold = 1'b0;
        if (ov_m && or_m) begin
          if (q_m.size() == 0) begin
            bad("m_unexpected", $sformatf("result tag=%h with empty scoreboard", otag_m));
          end else begin
            e = q_m.pop_front();
            check_resp("m_result", cur, e.r);
            if (e.exp_cyc >= 0) check_int("m_latency", cyc, e.exp_cyc);
          end
        end else if (ov_m) begin
          hold = 1'b1;
          held = cur;
        end
      end
    end
  end

  initial begin : mon_w
    sb_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n_v && ov_w && or_w) begin
        if (q_w.size() == 0) begin
          bad("w_unexpected", "result with empty scoreboard");
        end else begin
          e = q_w.pop_front();
          check_resp("w_result",
                     '{res: res_w, cout: co_w, ovf: ovf_w, zero: z_w, neg: ng_w, tag: otag_w}, e.r);
        end
      end
    end
  end

  initial begin : mon_n
    sb_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n_v && ov_n && or_n) begin
        if (q_n.size() == 0) begin
          bad("n_unexpected", "result with empty scoreboard");
        end else begin
          e = q_n.pop_front();
          check_resp("n_result",
                     '{res: 64'(res_n), cout: co_n, ovf: ovf_n, zero: z_n, neg: ng_n, tag: otag_n},
                     e.r);
        end
      end
    end
  end

  initial begin : drv_w
    int cnt;
    cnt  = 0;
    iv_w = 1'b0; or_w = 1'b1; op_w = OP_ADD; a_w = '0; b_w = '0; cin_w = 1'b0; tag_w = '0;
    wait (rst_n_v === 1'b1);
    while (cnt < NRand) begin
      @(negedge clk);
      iv_w  = ($urandom_range(3) != 0);
      op_w  = addsub_op_t'($urandom_range(3));
      a_w   = pick(64);
      b_w   = pick(64);
      cin_w = 1'($urandom_range(1));
      tag_w = 4'($urandom);
      or_w  = ($urandom_range(3) != 0);
      #1;
      if (iv_w && ir_w) begin
        q_w.push_back('{r: model(op_w, a_w, b_w, cin_w, 64, tag_w), exp_cyc: -1});
        cnt++;
      end
    end
    @(negedge clk);
    iv_w = 1'b0;
    or_w = 1'b1;
    done_w = 1'b1;
  end

  initial begin : drv_n
    int cnt;
    cnt  = 0;
    iv_n = 1'b0; or_n = 1'b1; op_n = OP_ADD; a_n = '0; b_n = '0; cin_n = 1'b0; tag_n = '0;
    wait (rst_n_v === 1'b1);
    while (cnt < NRand) begin
      @(negedge clk);
      iv_n  = ($urandom_range(3) != 0);
      op_n  = addsub_op_t'($urandom_range(3));
      a_n   = 8'(pick(8));
      b_n   = 8'(pick(8));
      cin_n = 1'($urandom_range(1));
      tag_n = 4'($urandom);
      or_n  = ($urandom_range(3) != 0);
      #1;
      if (iv_n && ir_n) begin
        q_n.push_back('{r: model(op_n, 64'(a_n), 64'(b_n), cin_n, 8, tag_n), exp_cyc: -1});
        cnt++;
      end
    end
    @(negedge clk);
    iv_n = 1'b0;
    or_n = 1'b1;
    done_n = 1'b1;
  end

  // Present one request at a negedge, hold it until accepted, then return at the next negedge
  task automatic send(input addsub_op_t op, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic [3:0] tag, input resp_t exp, input bit chk_lat);
    int waited;
    waited = 0;
    iv_m = 1'b1; op_m = op; a_m = a; b_m = b; cin_m = cin; tag_m = tag;
    #1;
    while (!ir_m && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (ir_m) begin
      q_m.push_back('{r: exp, exp_cyc: chk_lat ? cyc + Stages : -1});
      if (waited > 0) saw_block = 1'b1;
    end else begin
      bad("m_accept_timeout", $sformatf("in_ready low for %0d cycles, tag=%h", waited, tag));
    end
    @(negedge clk);
    iv_m = 1'b0;
  endtask

  task automatic send_rand(input logic [3:0] tag, input bit chk_lat);
    addsub_op_t op;
    logic [31:0] a, b;
    logic cin;
    op  = addsub_op_t'($urandom_range(3));
    a   = 32'(pick(32));
    b   = 32'(pick(32));
    cin = 1'($urandom_range(1));
    send(op, a, b, cin, tag, model(op, 64'(a), 64'(b), cin, 32, tag), chk_lat);
  endtask

  task automatic drain_m();
    int n;
    n = 0;
    while (q_m.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q_m.size() != 0) bad("m_drain_timeout", $sformatf("%0d results outstanding", q_m.size()));
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    rst_n_m = 1'b0; rst_n_v = 1'b0;
    iv_m = 1'b0; op_m = OP_ADD; a_m = '0; b_m = '0; cin_m = 1'b0; tag_m = '0;
    repeat (3) @(negedge clk);
    rst_n_m = 1'b1;
    rst_n_v = 1'b1;
    #1;
    check_int("rst_out_valid", int'(ov_m), 0);
    check_int("rst_in_ready", int'(ir_m), 1);
    check_resp("rst_outputs", cur_m(), '0);
    @(negedge clk);

    // Directed arithmetic corners, back-to-back, latency checked
    send(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'h1,
         '{res: 64'h0, cout: 1'b1, ovf: 1'b0, zero: 1'b1, neg: 1'b0, tag: 4'h1}, 1'b1);
    send(OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 4'h2,
         '{res: 64'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1, zero: 1'b0, neg: 1'b0, tag: 4'h2}, 1'b1);
    send(OP_SUB, 32'd3, 32'd5, 1'b0, 4'h3,
         '{res: 64'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b1, tag: 4'h3}, 1'b1);
    send(OP_ADC, 32'h0000_FFFF, 32'h0, 1'b1, 4'h4,
         '{res: 64'h0001_0000, cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b0, tag: 4'h4}, 1'b1);
    send(OP_SBC, 32'd10, 32'd3, 1'b0, 4'h5,
         '{res: 64'd6, cout: 1'b1, ovf: 1'b0, zero: 1'b0, neg: 1'b0, tag: 4'h5}, 1'b1);
    drain_m();

    // Ten back-to-back requests with the consumer stalled for four cycles
    stall_lo  = cyc + 5;
    stall_hi  = cyc + 8;
    saw_block = 1'b0;
    for (int i = 0; i < 10; i++) send_rand(4'(i), 1'b0);
    check_int("m_in_ready_drop", int'(saw_block), 1);
    drain_m();

    // Reset with three requests in flight
    for (int i = 0; i < 3; i++) send_rand(4'(8 + i), 1'b0);
    rst_n_m = 1'b0;
    q_m.delete();
    @(negedge clk);
    rst_n_m = 1'b1;
    #1;
    check_int("rst2_out_valid", int'(ov_m), 0);
    check_int("rst2_in_ready", int'(ir_m), 1);
    check_resp("rst2_outputs", cur_m(), '0);
    repeat (8) @(negedge clk);
    send_rand(4'hC, 1'b1);
    drain_m();

    // Random traffic with random consumer stalls
    rnd_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_rand(4'($urandom), 1'b0);
      if ($urandom_range(3) == 0) @(negedge clk);
    end
    rnd_mode = 1'b0;
    drain_m();

    n = 0;
    while (!(done_w && done_n) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!(done_w && done_n)) bad("variant_timeout", "variant drivers did not finish");
    n = 0;
    while ((q_w.size() != 0 || q_n.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q_w.size() != 0 || q_n.size() != 0)
      bad("variant_drain", $sformatf("outstanding w=%0d n=%0d", q_w.size(), q_n.size()));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
